// File: rtl/result_writeback.sv
// Result writeback: quantises array READ-phase results, buffers them and
// streams them to data memory at RESULT_BASE_ADDR + index.
module result_writeback #(
    parameter int                    ADDR_SIZE        = 10,
    parameter int                    ACC_W            = 24,
    parameter int                    DATA_W           = 8,
    parameter int                    SHIFT            = 0,
    parameter int                    FIFO_DEPTH       = 8,
    parameter logic [ADDR_SIZE-1:0]  RESULT_BASE_ADDR = 10'h200
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  read,
    input  logic [ACC_W-1:0]      acc_data,
    input  logic [7:0]            column_size,
    output logic                  wr_valid,
    input  logic                  wr_ready,
    output logic [ADDR_SIZE-1:0]  wr_addr,
    output logic [DATA_W-1:0]     wr_data,
    output logic                  busy,
    output logic                  done,
    output logic                  len_err,
    output logic                  ovf_err,
    input  logic                  clear_err
);

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CNT_W = AW + 1;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_DRAIN   = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    localparam logic signed [ACC_W-1:0] QMAX =
        ACC_W'((1 << (DATA_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] QMIN = ~QMAX;

    logic [1:0]             r_state;
    logic [7:0]             r_beats;
    logic [7:0]             r_col;
    logic [ADDR_SIZE-1:0]   r_index;
    logic [DATA_W-1:0]      r_mem [FIFO_DEPTH];
    logic [AW-1:0]          r_wptr;
    logic [AW-1:0]          r_rptr;
    logic [CNT_W-1:0]       r_count;
    logic                   r_len_err;
    logic                   r_ovf_err;

    logic signed [ACC_W-1:0] w_shift;
    logic [DATA_W-1:0]       w_q;
    logic                    w_valid;
    logic                    w_full;
    logic                    w_pop;
    logic                    w_push_req;
    logic                    w_push;
    logic                    w_drop;
    logic                    w_len_set;

    assign w_shift    = $signed(acc_data) >>> SHIFT;
    assign w_valid    = (r_count != '0);
    assign w_full     = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_pop      = w_valid && wr_ready;
    assign w_push_req = read && (r_state == S_IDLE || r_state == S_COLLECT);
    assign w_push     = w_push_req && (!w_full || w_pop);
    assign w_drop     = read && !w_push;
    assign w_len_set  = (r_state == S_COLLECT) && !read && (r_beats != r_col);

    // Saturate the shifted accumulator into the signed result range
    always_comb begin
        w_q = w_shift[DATA_W-1:0];
        if (w_shift > QMAX) begin
            w_q = QMAX[DATA_W-1:0];
        end else if (w_shift < QMIN) begin
            w_q = QMIN[DATA_W-1:0];
        end
    end

    // Result buffer storage; contents are only observed while non-empty
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= w_q;
        end
    end

    // Buffer pointers and occupancy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    // Burst sequencing, beat counting and write index
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_beats <= '0;
            r_col   <= '0;
            r_index <= '0;
        end else begin
            if (r_state == S_IDLE && read) begin
                r_index <= '0;
            end else if (w_pop) begin
                r_index <= r_index + ADDR_SIZE'(1);
            end
            unique case (r_state)
                S_IDLE: begin
                    if (read) begin
                        r_state <= S_COLLECT;
                        r_col   <= column_size;
                        r_beats <= 8'd1;
                    end
                end
                S_COLLECT: begin
                    if (read) begin
                        if (r_beats != 8'hFF) begin
                            r_beats <= r_beats + 8'd1;
                        end
                    end else begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (!w_valid) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Sticky error flags; a new error outranks a simultaneous clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_len_err <= 1'b0;
            r_ovf_err <= 1'b0;
        end else begin
            if (w_len_set) begin
                r_len_err <= 1'b1;
            end else if (clear_err) begin
                r_len_err <= 1'b0;
            end
            if (w_drop) begin
                r_ovf_err <= 1'b1;
            end else if (clear_err) begin
                r_ovf_err <= 1'b0;
            end
        end
    end

    assign wr_valid = w_valid;
    assign wr_data  = w_valid ? r_mem[r_rptr] : '0;
    assign wr_addr  = RESULT_BASE_ADDR + r_index;
    assign busy     = (r_state == S_COLLECT) || (r_state == S_DRAIN);
    assign done     = (r_state == S_DONE);
    assign len_err  = r_len_err;
    assign ovf_err  = r_ovf_err;

endmodule

// File: tb/tb_result_writeback.sv
// Bench for result_writeback: three parameterisations share one stimulus
// stream and are checked against a queue-based model every cycle.
module tb_result_writeback;

    localparam int DEPTH = 8;
    localparam int SH [3] = '{0, 4, 0};
    localparam int BA [3] = '{32'h200, 32'h200, 32'h3FE};

    localparam int PH_IDLE    = 0;
    localparam int PH_COLLECT = 1;
    localparam int PH_DRAIN   = 2;
    localparam int PH_DONE    = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic read = 1'b0;
    logic wr_ready = 1'b0;
    logic clear_err = 1'b0;
    logic [23:0] acc_data = '0;
    logic [7:0] column_size = '0;

    logic [2:0] wv, busy, done, lerr, oerr;
    logic [2:0][7:0] wd;
    logic [2:0][9:0] wa;

    int errors = 0;
    int checks = 0;
    bit rnd = 1'b0;
    int done_cnt = 0;
    int la0[$], ld0[$], ld1[$], la2[$];
    int vals[$];

    int mq[$];
    int m_ph = PH_IDLE;
    int m_idx = 0;
    int m_beats = 0;
    int m_col = 0;
    bit m_len = 1'b0;
    bit m_ovf = 1'b0;

    always #5 clk = ~clk;

    result_writeback #(.SHIFT(0)) u0 (
        .clk(clk), .reset(reset), .read(read), .acc_data(acc_data),
        .column_size(column_size), .wr_valid(wv[0]), .wr_ready(wr_ready),
        .wr_addr(wa[0]), .wr_data(wd[0]), .busy(busy[0]), .done(done[0]),
        .len_err(lerr[0]), .ovf_err(oerr[0]), .clear_err(clear_err)
    );

    result_writeback #(.SHIFT(4)) u1 (
        .clk(clk), .reset(reset), .read(read), .acc_data(acc_data),
        .column_size(column_size), .wr_valid(wv[1]), .wr_ready(wr_ready),
        .wr_addr(wa[1]), .wr_data(wd[1]), .busy(busy[1]), .done(done[1]),
        .len_err(lerr[1]), .ovf_err(oerr[1]), .clear_err(clear_err)
    );

    result_writeback #(.RESULT_BASE_ADDR(10'h3FE)) u2 (
        .clk(clk), .reset(reset), .read(read), .acc_data(acc_data),
        .column_size(column_size), .wr_valid(wv[2]), .wr_ready(wr_ready),
        .wr_addr(wa[2]), .wr_data(wd[2]), .busy(busy[2]), .done(done[2]),
        .len_err(lerr[2]), .ovf_err(oerr[2]), .clear_err(clear_err)
    );

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic int quant(input int a, input int sh);
        int v;
        v = a >>> sh;
        if (v > 127) v = 127;
        if (v < -128) v = -128;
        return v & 255;
    endfunction

    function automatic int at(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return -1;
    endfunction

    function automatic logic [23:0] rand_acc();
        if ($urandom_range(0, 1) == 1)
            return 24'($urandom_range(0, 511)) - 24'd256;
        return 24'($urandom);
    endfunction

    // Reference model: one queue of raw results, advanced on each edge
    initial begin
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                mq.delete();
                m_ph = PH_IDLE;
                m_idx = 0;
                m_beats = 0;
                m_col = 0;
                m_len = 1'b0;
                m_ovf = 1'b0;
            end else begin
                int pre_n;
                bit lset, oset;
                pre_n = mq.size();
                lset = 1'b0;
                oset = 1'b0;
                if (pre_n > 0 && wr_ready) begin
                    void'(mq.pop_front());
                    m_idx++;
                end
                case (m_ph)
                    PH_IDLE: if (read) begin
                        m_ph = PH_COLLECT;
                        m_col = int'(column_size);
                        m_beats = 1;
                        m_idx = 0;
                        mq.push_back(int'($signed(acc_data)));
                    end
                    PH_COLLECT: if (read) begin
                        if (m_beats < 255) m_beats++;
                        if (mq.size() < DEPTH)
                            mq.push_back(int'($signed(acc_data)));
                        else
                            oset = 1'b1;
                    end else begin
                        m_ph = PH_DRAIN;
                        if (m_beats != m_col) lset = 1'b1;
                    end
                    PH_DRAIN: begin
                        if (read) oset = 1'b1;
                        if (pre_n == 0) m_ph = PH_DONE;
                    end
                    default: begin
                        if (read) oset = 1'b1;
                        m_ph = PH_IDLE;
                    end
                endcase
                if (lset) m_len = 1'b1;
                else if (clear_err) m_len = 1'b0;
                if (oset) m_ovf = 1'b1;
                else if (clear_err) m_ovf = 1'b0;
            end
        end
    end

    // Per-cycle comparison of every DUT against the model, plus write log
    initial begin
        forever begin
            @(negedge clk);
            #2;
            for (int d = 0; d < 3; d++) begin
                bit ev;
                ev = (mq.size() > 0);
                check($sformatf("d%0d_valid", d), 32'(wv[d]), 32'(ev));
                if (ev)
                    check($sformatf("d%0d_data", d), 32'(wd[d]),
                          32'(quant(mq[0], SH[d])));
                check($sformatf("d%0d_addr", d), 32'(wa[d]),
                      32'((BA[d] + m_idx) & 32'h3FF));
                check($sformatf("d%0d_busy", d), 32'(busy[d]),
                      32'(m_ph == PH_COLLECT || m_ph == PH_DRAIN));
                check($sformatf("d%0d_done", d), 32'(done[d]),
                      32'(m_ph == PH_DONE));
                check($sformatf("d%0d_len", d), 32'(lerr[d]), 32'(m_len));
                check($sformatf("d%0d_ovf", d), 32'(oerr[d]), 32'(m_ovf));
            end
            if (!reset) begin
                if (done[0]) done_cnt++;
                if (wv[0] && wr_ready) begin
                    la0.push_back(int'(wa[0]));
                    ld0.push_back(int'(wd[0]));
                end
                if (wv[1] && wr_ready) ld1.push_back(int'(wd[1]));
                if (wv[2] && wr_ready) la2.push_back(int'(wa[2]));
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        if (rnd) begin
            wr_ready = ($urandom_range(0, 9) < 7);
            clear_err = ($urandom_range(0, 9) == 0);
        end
    endtask

    task automatic burst(input int col, input int n, input bit use_vals);
        for (int i = 0; i < n; i++) begin
            tick();
            read = 1'b1;
            column_size = 8'(col);
            acc_data = use_vals ? 24'(vals[i]) : rand_acc();
        end
        tick();
        read = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while ((busy[0] || done[0]) && k < 500) begin
            tick();
            #1;
            k++;
        end
        check("drain_timeout", 32'(busy[0]), 32'd0);
    endtask

    task automatic clear_logs();
        la0.delete();
        ld0.delete();
        ld1.delete();
        la2.delete();
        done_cnt = 0;
    endtask

    initial begin
        @(negedge clk);
        #1;
        check("rst_valid", 32'(wv[0]), 32'd0);
        check("rst_addr", 32'(wa[0]), 32'h200);
        check("rst_addr_b3fe", 32'(wa[2]), 32'h3FE);
        check("rst_data", 32'(wd[0]), 32'd0);
        check("rst_busy", 32'(busy[0]), 32'd0);
        check("rst_done", 32'(done[0]), 32'd0);
        check("rst_len", 32'(lerr[0]), 32'd0);
        check("rst_ovf", 32'(oerr[0]), 32'd0);
        tick();
        reset = 1'b0;

        // Four-beat burst, memory always ready
        wr_ready = 1'b1;
        vals = '{1, 2, 3, 4};
        clear_logs();
        burst(4, 4, 1'b1);
        wait_idle();
        tick();
        #1;
        check("t1_count", 32'(la0.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check("t1_addr", 32'(at(la0, i)), 32'(32'h200 + i));
            check("t1_data", 32'(at(ld0, i)), 32'(i + 1));
        end
        check("t1_wrap0", 32'(at(la2, 0)), 32'h3FE);
        check("t1_wrap1", 32'(at(la2, 1)), 32'h3FF);
        check("t1_wrap2", 32'(at(la2, 2)), 32'h000);
        check("t1_wrap3", 32'(at(la2, 3)), 32'h001);
        check("t1_done", 32'(done_cnt), 32'd1);
        check("t1_len", 32'(lerr[0]), 32'd0);

        // Shift-by-4 quantisation with saturation both ways
        vals = '{32'h000800, 32'hFFF000, 32'h000050};
        clear_logs();
        burst(3, 3, 1'b1);
        wait_idle();
        check("t2_q0", 32'(at(ld1, 0)), 32'h7F);
        check("t2_q1", 32'(at(ld1, 1)), 32'h80);
        check("t2_q2", 32'(at(ld1, 2)), 32'h05);

        // Overflow with memory stalled, then drain
        wr_ready = 1'b0;
        vals.delete();
        for (int i = 0; i < 10; i++) vals.push_back(10 + i);
        clear_logs();
        burst(10, 10, 1'b1);
        tick();
        #1;
        check("t3_ovf", 32'(oerr[0]), 32'd1);
        check("t3_valid", 32'(wv[0]), 32'd1);
        wr_ready = 1'b1;
        wait_idle();
        tick();
        #1;
        check("t3_count", 32'(ld0.size()), 32'd8);
        check("t3_first", 32'(at(ld0, 0)), 32'd10);
        check("t3_last", 32'(at(ld0, 7)), 32'd17);
        check("t3_done", 32'(done_cnt), 32'd1);
        check("t3_len", 32'(lerr[0]), 32'd0);

        // Clear, then a short burst against a larger column size
        tick();
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        #1;
        check("t4_ovf_clr", 32'(oerr[0]), 32'd0);
        vals = '{5, 6, 7};
        burst(5, 3, 1'b1);
        tick();
        #1;
        check("t4_len", 32'(lerr[0]), 32'd1);
        wait_idle();
        tick();
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        #1;
        check("t4_len_clr", 32'(lerr[0]), 32'd0);

        // Reset with results still buffered
        wr_ready = 1'b0;
        burst(3, 3, 1'b1);
        tick();
        #1;
        check("t5_buffered", 32'(wv[0]), 32'd1);
        reset = 1'b1;
        #1;
        check("t5_valid", 32'(wv[0]), 32'd0);
        check("t5_busy", 32'(busy[0]), 32'd0);
        check("t5_addr", 32'(wa[0]), 32'h200);
        check("t5_data", 32'(wd[0]), 32'd0);
        tick();
        reset = 1'b0;
        wr_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            #1;
            check("t5_quiet", 32'(wv[0]), 32'd0);
        end

        // Randomised bursts, stalls, stray beats and clears
        rnd = 1'b1;
        for (int b = 0; b < 60; b++) begin
            int col, n;
            col = $urandom_range(0, 12);
            if ($urandom_range(0, 2) == 0) n = (col == 0) ? 1 : col;
            else n = $urandom_range(1, 14);
            burst(col, n, 1'b0);
            if ($urandom_range(0, 3) == 0) begin
                tick();
                read = 1'b1;
                acc_data = rand_acc();
                tick();
                read = 1'b0;
            end
            wait_idle();
            repeat ($urandom_range(0, 2)) tick();
        end
        rnd = 1'b0;
        wr_ready = 1'b1;
        clear_err = 1'b0;
        wait_idle();

        // Beat counter saturates at 255
        tick();
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        burst(255, 260, 1'b0);
        tick();
        #1;
        check("sat_len", 32'(lerr[0]), 32'd0);
        wait_idle();
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
